// File: rtl/rx_fifo_ctrl.sv
// Receive-side sequencer: captures UART receiver bytes into a small FIFO, acknowledges them with data_read, and keeps saturating error counts.
// Latency: data_read one cycle after data_ready is sampled; the entry is visible on rd_* one edge later. Backpressure: a full FIFO leaves the byte waiting in the receiver.
module rx_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_ready,
    input  logic [7:0]               rx_data,
    input  logic                     overrun_error,
    input  logic                     framing_error,
    output logic                     data_read,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    output logic                     rd_ferr,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         ovr_cnt,
    output logic [CNT_W-1:0]         ferr_cnt,
    input  logic                     clr_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [8:0]      mem [DEPTH];
    logic            ovr_prev;
    logic            wr_en;
    logic            pop;
    logic            ovr_rise;

    assign wr_en    = (state == CAPTURE);
    assign rd_valid = (fifo_count != '0);
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = mem[rd_ptr][7:0];
    assign rd_ferr  = mem[rd_ptr][8];
    assign ovr_rise = overrun_error & ~ovr_prev;

    // Storage needs no reset: contents are ignored while fifo_count is zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_ptr] <= {framing_error, rx_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_read  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovr_prev   <= 1'b0;
            ovr_cnt    <= '0;
            ferr_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_ready && (fifo_count < FULL_LVL)) begin
                        state     <= CAPTURE;
                        data_read <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state     <= WAIT_CLR;
                    data_read <= 1'b0;
                end
                WAIT_CLR: begin
                    data_read <= 1'b0;
                    if (!data_ready)
                        state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    data_read <= 1'b0;
                end
            endcase

            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            // Clear wins over any same-cycle increment.
            ovr_prev <= overrun_error;
            if (clr_cnt) begin
                ovr_cnt  <= '0;
                ferr_cnt <= '0;
            end else begin
                if (ovr_rise && (ovr_cnt != '1))
                    ovr_cnt <= ovr_cnt + 1'b1;
                if (wr_en && framing_error && (ferr_cnt != '1))
                    ferr_cnt <= ferr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl; a second instance with 2-bit counters exercises saturation.
module tb_rx_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready, overrun_error, framing_error, rd_ready, clr_cnt;
    logic [7:0] rx_data;
    logic       data_read, rd_valid, rd_ferr;
    logic [7:0] rd_data;
    logic [2:0] fifo_count;
    logic [7:0] ovr_cnt, ferr_cnt;

    logic       ovr2, clr2;
    logic       data_read2, rd_valid2, rd_ferr2;
    logic [7:0] rd_data2;
    logic [2:0] fifo_count2;
    logic [1:0] ovr_cnt2, ferr_cnt2;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    rx_fifo_ctrl #(.DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .data_ready(data_ready), .rx_data(rx_data),
        .overrun_error(overrun_error), .framing_error(framing_error),
        .data_read(data_read), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ferr(rd_ferr), .rd_ready(rd_ready), .fifo_count(fifo_count),
        .ovr_cnt(ovr_cnt), .ferr_cnt(ferr_cnt), .clr_cnt(clr_cnt)
    );

    rx_fifo_ctrl #(.DEPTH(4), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_ready(1'b0), .rx_data(8'h00),
        .overrun_error(ovr2), .framing_error(1'b0),
        .data_read(data_read2), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .rd_ferr(rd_ferr2), .rd_ready(1'b0), .fifo_count(fifo_count2),
        .ovr_cnt(ovr_cnt2), .ferr_cnt(ferr_cnt2), .clr_cnt(clr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the data_read pulse with data_ready already high.
    task automatic wait_read(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (data_read === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // Finish the handshake after data_read was seen: drop data_ready, confirm single-cycle pulse.
    task automatic finish_capture(input string tag);
        data_ready = 1'b0;
        tick();
        check(tag, {31'd0, data_read}, 32'd0);
        tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe);
        rx_data       = d;
        framing_error = fe;
        data_ready    = 1'b1;
        sb_q.push_back({fe, d});
        wait_read("send_dr");
        finish_capture("send_pulse");
    endtask

    task automatic pop_check(input string tag);
        logic [8:0] exp;
        check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sbempty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check(tag, {23'd0, rd_ferr, rd_data}, {23'd0, exp});
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_ready = 1'b1; rx_data = 8'h11; framing_error = 1'b0;
        overrun_error = 1'b0; rd_ready = 1'b0; clr_cnt = 1'b0; ovr2 = 1'b0; clr2 = 1'b0;

        // Reset held two cycles with data_ready asserted
        tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_dr", {31'd0, data_read}, 32'd0);
            check("rst_vld", {31'd0, rd_valid}, 32'd0);
            check("rst_cnt", {29'd0, fifo_count}, 32'd0);
            check("rst_ovr", {24'd0, ovr_cnt}, 32'd0);
            check("rst_ferr", {24'd0, ferr_cnt}, 32'd0);
            if (i == 0) tick();
        end
        rst = 1'b0;
        sb_q.push_back({1'b0, 8'h11});
        tick();
        check("rel_dr", {31'd0, data_read}, 32'd1);
        finish_capture("rel_pulse");
        pop_check("rel_pop");

        // Single byte with exact latency
        rx_data = 8'hA5; framing_error = 1'b0; data_ready = 1'b1;
        sb_q.push_back({1'b0, 8'hA5});
        tick();
        check("single_dr", {31'd0, data_read}, 32'd1);
        check("single_vld0", {31'd0, rd_valid}, 32'd0);
        finish_capture("single_pulse");
        check("single_cnt", {29'd0, fifo_count}, 32'd1);
        pop_check("single_pop");
        check("single_cnt0", {29'd0, fifo_count}, 32'd0);

        // Full FIFO and pointer wrap
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b0);
        check("full_cnt", {29'd0, fifo_count}, 32'd4);
        rx_data = 8'h05; framing_error = 1'b0; data_ready = 1'b1;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (data_read === 1'b1) got = 1'b1;
            end
            check("full_nodr", {31'd0, got}, 32'd0);
        end
        check("full_cnt2", {29'd0, fifo_count}, 32'd4);
        pop_check("full_pop1");
        sb_q.push_back({1'b0, 8'h05});
        wait_read("full_dr5");
        finish_capture("full_pulse5");
        check("full_cnt3", {29'd0, fifo_count}, 32'd4);
        for (int i = 0; i < 4; i++) pop_check("wrap_pop");
        check("wrap_cnt0", {29'd0, fifo_count}, 32'd0);

        // Simultaneous write and pop
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        rx_data = 8'h23; framing_error = 1'b0; data_ready = 1'b1;
        sb_q.push_back({1'b0, 8'h23});
        tick();
        check("sim_dr", {31'd0, data_read}, 32'd1);
        pop_check("sim_pop");
        check("sim_cnt", {29'd0, fifo_count}, 32'd2);
        finish_capture("sim_pulse");
        pop_check("sim_pop2");
        pop_check("sim_pop3");

        // Framing error capture
        send_byte(8'h3C, 1'b1);
        check("ferr_cnt", {24'd0, ferr_cnt}, 32'd1);
        pop_check("ferr_pop");
        framing_error = 1'b0;

        // Overrun held high counts one edge
        overrun_error = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        overrun_error = 1'b0;
        tick();
        check("ovr_hold", {24'd0, ovr_cnt}, 32'd1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_ovr", {24'd0, ovr_cnt}, 32'd0);
        check("clr_ferr", {24'd0, ferr_cnt}, 32'd0);

        // Saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            ovr2 = 1'b1; tick();
            ovr2 = 1'b0; tick();
        end
        check("sat_ovr2", {30'd0, ovr_cnt2}, 32'd3);
        ovr2 = 1'b1; clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check("clr_edge_ovr2", {30'd0, ovr_cnt2}, 32'd0);
        tick();
        check("clr_hold_ovr2", {30'd0, ovr_cnt2}, 32'd0);
        ovr2 = 1'b0;

        // Reset while in CAPTURE drops the pulse and the FIFO
        send_byte(8'h44, 1'b0);
        rx_data = 8'h55; data_ready = 1'b1;
        tick();
        check("mid_dr", {31'd0, data_read}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_dr", {31'd0, data_read}, 32'd0);
        check("mid_rst_cnt", {29'd0, fifo_count}, 32'd0);
        check("mid_rst_vld", {31'd0, rd_valid}, 32'd0);
        sb_q.delete();
        rst = 1'b0; data_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
